mem_bus: RTL and testbench



---
 rtl/mem_bus.sv | 186 ++++++++++++++++++
 tb/tb_mem_bus.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus.sv
// mem_bus: PicoRV32-native bus slave for on-chip word RAM and, with MEM_BUS_UART_EN defined, an 8N1 UART TX.
// Requests complete 2 cycles after valid; a TXDATA write while the UART is busy stalls until the frame ends.
module mem_bus #(
    parameter int RAM_WORDS = 1024,
    parameter int CLK_DIV   = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        bus_err
);
    localparam int AW = $clog2(RAM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_RESP, S_STALL} req_state_t;
    req_state_t r_state, w_next;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [31:0]   r_rdata;
    logic          r_bus_err;
    logic          w_accept;
    logic          w_is_ram;
    logic          w_is_tx;
    logic          w_is_st;
    logic          w_busy;
    logic          w_tx_stall;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign w_accept   = (r_state == S_IDLE) && mem_valid;
    assign w_is_ram   = (mem_addr[31:AW+2] == '0);
    assign w_idx      = mem_addr[AW+1:2];
    assign w_tx_stall = w_is_tx && mem_wstrb[0] && w_busy;
    assign w_unused   = ^{mem_instr, mem_addr[1:0]} ^ (CLK_DIV < 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_valid) begin
                    w_next = w_tx_stall ? S_STALL : S_RESP;
                end
            end
            S_STALL: begin
                if (!w_busy) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // RAM has no reset; read returns the pre-write word on the same edge.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    r_ram[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else if (w_accept) begin
            if (w_is_ram) begin
                r_rdata <= r_ram[w_idx];
            end else if (w_is_st) begin
                r_rdata <= {31'b0, w_busy};
            end else begin
                r_rdata <= '0;
            end
            if (!(w_is_ram || w_is_tx || w_is_st)) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign mem_ready = (r_state == S_RESP);
    assign mem_rdata = (r_state == S_RESP) ? r_rdata : '0;
    assign bus_err   = r_bus_err;

`ifdef MEM_BUS_UART_EN
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    uart_state_t r_ustate, w_unext;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shreg;
    logic [7:0]    r_tx_byte;
    logic          w_bit_end;
    logic          w_load;
    logic [7:0]    w_load_byte;
    logic          w_tx;

    assign w_is_tx     = (mem_addr == 32'h1000_0000);
    assign w_is_st     = (mem_addr == 32'h1000_0004);
    assign w_busy      = (r_ustate != U_IDLE);
    assign w_bit_end   = (r_cnt == CW'(CLK_DIV - 1));
    // A stalled write loads the byte captured at accept, once the previous frame has drained.
    assign w_load      = !w_busy && ((w_accept && w_is_tx && mem_wstrb[0]) || (r_state == S_STALL));
    assign w_load_byte = (r_state == S_STALL) ? r_tx_byte : mem_wdata[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ustate <= U_IDLE;
        end else begin
            r_ustate <= w_unext;
        end
    end

    always_comb begin
        w_unext = r_ustate;
        w_tx    = 1'b1;
        case (r_ustate)
            U_IDLE: begin
                if (w_load) w_unext = U_START;
            end
            U_START: begin
                w_tx = 1'b0;
                if (w_bit_end) w_unext = U_DATA;
            end
            U_DATA: begin
                w_tx = r_shreg[r_bit];
                if (w_bit_end && (r_bit == 3'd7)) w_unext = U_STOP;
            end
            U_STOP: begin
                if (w_bit_end) w_unext = U_IDLE;
            end
            default: w_unext = U_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shreg   <= '0;
            r_tx_byte <= '0;
        end else begin
            if (w_accept && w_is_tx) begin
                r_tx_byte <= mem_wdata[7:0];
            end
            if (w_load) begin
                r_cnt   <= '0;
                r_bit   <= '0;
                r_shreg <= w_load_byte;
            end else if (r_ustate != U_IDLE) begin
                if (w_bit_end) begin
                    r_cnt <= '0;
                    if (r_ustate == U_DATA) r_bit <= r_bit + 3'd1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign uart_tx = w_tx;
`else
    assign w_is_tx = 1'b0;
    assign w_is_st = 1'b0;
    assign w_busy  = 1'b0;
    assign uart_tx = 1'b1;
`endif
endmodule

// File: tb/tb_mem_bus.sv
// Directed bench for mem_bus: RAM byte writes, address decode, bus_err, reset abort, and UART frames
// when MEM_BUS_UART_EN is defined.
module tb_mem_bus;
    localparam int RW  = 256;
    localparam int DIV = 4;
    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus #(.RAM_WORDS(RW), .CLK_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    // lat = rising edges from raising valid until mem_ready is seen; 200 means it never came.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output int lat, output logic tx_at_rdy);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        mem_valid = 1'b1;
        lat       = 0;
        rdata     = '0;
        tx_at_rdy = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mem_ready === 1'b1) break;
        end
        if (lat >= 200) lat = 200;
        rdata     = mem_rdata;
        tx_at_rdy = uart_tx;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input string tag);
        logic [31:0] d;
        int          lat;
        logic        t;
        bus_xfer(addr, data, strb, d, lat, t);
        check({tag, "_lat"}, lat, 1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        int          lat;
        logic        t;
        bus_xfer(addr, 32'h0, 4'h0, d, lat, t);
        check({tag, "_lat"}, lat, 1);
        check({tag, "_data"}, d, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat;
        int          lat2;
        int          to;
        logic        t;

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", mem_ready, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_tx", uart_tx, 1);
        check("rst_err", bus_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        wr(32'h10, 32'hDEAD_BEEF, 4'hF, "wr_full");
        rd(32'h10, 32'hDEAD_BEEF, "rd_full");
        @(negedge clk);
        check("idle_ready", mem_ready, 0);
        check("idle_rdata", mem_rdata, 0);

        wr(32'h10, 32'h0000_00AA, 4'b0001, "wr_b0");
        rd(32'h10, 32'hDEAD_BEAA, "rd_b0");
        wr(32'h14, 32'h1234_5678, 4'hF, "wr_w5");
        wr(32'h17, 32'h0000_CD00, 4'b0010, "wr_b1");
        rd(32'h14, 32'h1234_CD78, "rd_b1");
        mem_instr = 1'b1;
        rd(32'h12, 32'hDEAD_BEAA, "fetch");
        mem_instr = 1'b0;
        wr(RW*4-4, 32'hCAFE_F00D, 4'hF, "wr_last");
        rd(RW*4-4, 32'hCAFE_F00D, "rd_last");
        check("err_clean", bus_err, 0);

`ifdef MEM_BUS_UART_EN
        to = 0;
        fork
            begin
                while (uart_tx !== 1'b0 && to < 20) begin
                    @(negedge clk);
                    to++;
                end
                check("tx_start_seen", (to < 20), 1);
                for (int k = 0; k < 40; k++) begin
                    if (k > 0) @(negedge clk);
                    check($sformatf("tx55_bit%0d", k / 4), uart_tx, frame_bit(8'h55, k / 4));
                end
            end
            begin
                wr(A_TX, 32'h0000_0055, 4'b0001, "wr_tx55");
                rd(A_ST, 32'h1, "st_busy");
            end
        join
        repeat (2) @(posedge clk);
        #1;
        rd(A_ST, 32'h0, "st_idle");

        bus_xfer(A_TX, 32'hA5, 4'b0001, d, lat, t);
        check("b2b_lat1", lat, 1);
        bus_xfer(A_TX, 32'h3C, 4'b0001, d, lat2, t);
        check("b2b_lat2", lat2, 10 * DIV);
        check("b2b_tx_start", t, 0);
        repeat (45) @(posedge clk);
        #1;
        check("err_uart", bus_err, 0);
`else
        rd(A_TX, 32'h0, "tx_unmapped");
        check("err_tx", bus_err, 1);
        reset = 1'b1;
        #1;
        check("err_rst", bus_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        rd(A_ST, 32'h0, "st_unmapped");
        check("err_st", bus_err, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
`endif

        check("err_pre", bus_err, 0);
        rd(32'h2000_0000, 32'h0, "unmapped");
        check("err_set", bus_err, 1);
        rd(RW*4, 32'h0, "past_ram");
        rd(32'h10, 32'hDEAD_BEAA, "rd_after_err");
        check("err_sticky", bus_err, 1);

`ifdef MEM_BUS_UART_EN
        wr(A_TX, 32'h0000_0081, 4'b0001, "wr_tx_pre_rst");
`endif
        mem_addr  = 32'h10;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_ready", mem_ready, 1);
`ifdef MEM_BUS_UART_EN
        check("pre_rst_tx", uart_tx, 0);
`endif
        reset = 1'b1;
        #1;
        check("mid_rst_ready", mem_ready, 0);
        check("mid_rst_rdata", mem_rdata, 0);
        check("mid_rst_tx", uart_tx, 1);
        check("mid_rst_err", bus_err, 0);
        mem_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
`ifdef MEM_BUS_UART_EN
        rd(A_ST, 32'h0, "st_after_rst");
`endif
        rd(32'h10, 32'hDEAD_BEAA, "rd_after_rst");
        check("err_after_rst", bus_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
